// File: rtl/fsmc_bank_arbiter.sv
// FSMC slave front-end and host/engine arbiter for the shared 16x8 register bank.
// Host strobes are synchronised into CLK; host cycles become bank requests that
// take priority over the engine, and a starvation counter forces an engine grant
// after STARVE_MAX consecutive host grants while the engine waits.
//
// state | meaning
// IDLE  | no bank access; pick the next requester
// HWR   | host write to the bank
// HRD   | host read issued to the bank
// HRD_W | bank read data returning, load FSMC_D_OUT
// IACC  | engine access issued, int_gnt pulsed
// IRD_W | bank read data returning, load int_rdata
module fsmc_bank_arbiter #(
   parameter int CS_SEL     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] FSMC_A,
   input  logic [1:0] FSMC_NE,
   input  logic       FSMC_NOE,
   input  logic       FSMC_NWE,
   input  logic [7:0] FSMC_D_IN,
   output logic [7:0] FSMC_D_OUT,
   output logic       FSMC_D_OE,
   input  logic       int_req,
   input  logic       int_we,
   input  logic [3:0] int_addr,
   input  logic [7:0] int_wdata,
   output logic       int_gnt,
   output logic [7:0] int_rdata,
   output logic       int_rvalid,
   output logic       mem_en,
   output logic       mem_we,
   output logic [3:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic       bus_err
);

   typedef enum logic [2:0] {IDLE, HWR, HRD, HRD_W, IACC, IRD_W} state_t;

   localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

   state_t     state, state_nxt;
   logic [2:0] ne_sync, noe_sync, nwe_sync;
   logic       selected, wr_fall, rd_fall, rd_new, wr_any, rd_any, forced;
   logic       wr_pend, rd_pend;
   logic [3:0] wr_addr, rd_addr;
   logic [7:0] wr_data;
   logic [3:0] starve_cnt;

   // the pad driver follows the raw pins so the bus turns around without CLK latency
   assign FSMC_D_OE = ~FSMC_NE[CS_SEL] & ~FSMC_NOE;

   // [0] and [1] form the synchroniser, [2] is the history flop for edge detection
   always_ff @(posedge CLK) begin
      if (RST) begin
         ne_sync  <= 3'b111;
         noe_sync <= 3'b111;
         nwe_sync <= 3'b111;
      end else begin
         ne_sync  <= {ne_sync[1:0], FSMC_NE[CS_SEL]};
         noe_sync <= {noe_sync[1:0], FSMC_NOE};
         nwe_sync <= {nwe_sync[1:0], FSMC_NWE};
      end
   end

   assign selected = ~ne_sync[1];
   assign wr_fall  = selected & nwe_sync[2] & ~nwe_sync[1];
   assign rd_fall  = selected & noe_sync[2] & ~noe_sync[1];
   // a read that coincides with a write is a bus error and is dropped
   assign rd_new   = rd_fall & ~wr_fall;
   // a fresh edge is usable in IDLE the same cycle, saving one CLK of host latency
   assign wr_any   = wr_pend | wr_fall;
   assign rd_any   = rd_pend | rd_new;
   assign forced   = (starve_cnt == STARVE_MAX_C) & int_req;

   // host request capture; a new edge overwrites a request not yet serviced
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_pend <= 1'b0;
         rd_pend <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         rd_addr <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= wr_fall & rd_fall;
         if (wr_fall) begin
            wr_pend <= 1'b1;
            wr_addr <= FSMC_A;
            wr_data <= FSMC_D_IN;
         end else if (state == HWR) begin
            wr_pend <= 1'b0;
         end
         if (rd_new) begin
            rd_pend <= 1'b1;
            rd_addr <= FSMC_A;
         end else if (state == HRD) begin
            rd_pend <= 1'b0;
         end
      end
   end

   // counts host grants taken while the engine is waiting
   always_ff @(posedge CLK) begin
      if (RST) begin
         starve_cnt <= '0;
      end else begin
         case (state)
            IDLE:     if (!int_req) starve_cnt <= '0;
            HWR, HRD: if (int_req && starve_cnt < STARVE_MAX_C) starve_cnt <= starve_cnt + 4'd1;
            IACC:     starve_cnt <= '0;
            default:  ;
         endcase
      end
   end

   // state register and registered read-data returns
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         FSMC_D_OUT <= '0;
         int_rdata  <= '0;
         int_rvalid <= 1'b0;
      end else begin
         state      <= state_nxt;
         int_rvalid <= (state == IRD_W);
         if (state == HRD_W) FSMC_D_OUT <= mem_rdata;
         if (state == IRD_W) int_rdata  <= mem_rdata;
      end
   end

   // next state and bank port drive; address/data are zero when the port is idle
   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      int_gnt   = 1'b0;
      case (state)
         IDLE: begin
            if (wr_any && !forced)      state_nxt = HWR;
            else if (rd_any && !forced) state_nxt = HRD;
            else if (int_req)           state_nxt = IACC;
         end
         HWR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            state_nxt = IDLE;
         end
         HRD: begin
            mem_en    = 1'b1;
            mem_addr  = rd_addr;
            state_nxt = HRD_W;
         end
         HRD_W: state_nxt = IDLE;
         IACC: begin
            mem_en    = 1'b1;
            mem_we    = int_we;
            mem_addr  = int_addr;
            mem_wdata = int_we ? int_wdata : 8'h00;
            int_gnt   = 1'b1;
            state_nxt = int_we ? IDLE : IRD_W;
         end
         IRD_W:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (RST) begin
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         int_gnt   = 1'b0;
      end
   end

endmodule

// File: tb/tb_fsmc_bank_arbiter.sv
// Bench for fsmc_bank_arbiter: directed scenarios plus randomized serialized
// host/engine traffic against a reference copy of the bank contents.
module tb_fsmc_bank_arbiter;

   localparam int CS         = 1;
   localparam int STARVE_MAX = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] fsmc_a;
   logic [1:0] ne;
   logic       noe, nwe;
   logic [7:0] d_in, d_out;
   logic       d_oe;
   logic       int_req, int_we;
   logic [3:0] int_addr;
   logic [7:0] int_wdata, int_rdata;
   logic       int_gnt, int_rvalid;
   logic       mem_en, mem_we;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic       bus_err;

   logic [7:0]  bank     [16];
   logic [7:0]  init_mem [16];
   logic [7:0]  ref_mem  [16];
   logic        bank_load;
   logic [11:0] exp_wr [$];
   logic [7:0]  exp_rd [$];
   logic        mon_wr_en;
   logic [7:0]  last_rd;
   int          n_cmp = 0;
   int          n_err = 0;

   fsmc_bank_arbiter #(.CS_SEL(CS), .STARVE_MAX(STARVE_MAX)) dut (
      .CLK(clk), .RST(rst), .FSMC_A(fsmc_a), .FSMC_NE(ne), .FSMC_NOE(noe),
      .FSMC_NWE(nwe), .FSMC_D_IN(d_in), .FSMC_D_OUT(d_out), .FSMC_D_OE(d_oe),
      .int_req(int_req), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
      .int_gnt(int_gnt), .int_rdata(int_rdata), .int_rvalid(int_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // external single-port bank, 1-cycle read latency
   always @(posedge clk) begin
      if (bank_load) begin
         for (int i = 0; i < 16; i++) bank[i] <= init_mem[i];
         mem_rdata <= 8'h00;
      end else if (mem_en) begin
         if (mem_we) bank[mem_addr] <= mem_wdata;
         else        mem_rdata      <= bank[mem_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int val, input int lo, input int hi);
      n_cmp++;
      if (val < lo || val > hi) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
      end
   endtask

   // monitor: engine read returns, bank writes and idle-port cleanliness
   initial begin
      logic        g1, g2;
      logic [11:0] ew;
      logic [7:0]  er;
      g1 = 1'b0;
      g2 = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            g1 = 1'b0;
            g2 = 1'b0;
         end else begin
            check("rvalid_timing", 32'(int_rvalid), 32'(g2));
            if (int_rvalid) begin
               if (exp_rd.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_rvalid: got data %0h expected none", int_rdata);
               end else begin
                  er = exp_rd.pop_front();
                  check("int_rdata", 32'(int_rdata), 32'(er));
               end
            end
            if (mem_en && mem_we && mon_wr_en) begin
               if (exp_wr.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
               end else begin
                  ew = exp_wr.pop_front();
                  check("bank_wr_addr", 32'(mem_addr), 32'(ew[11:8]));
                  check("bank_wr_data", 32'(mem_wdata), 32'(ew[7:0]));
               end
            end
            if (!mem_en) begin
               check("idle_addr", 32'(mem_addr), 32'd0);
               check("idle_wdata", 32'(mem_wdata), 32'd0);
            end
            g2 = g1;
            g1 = int_gnt & ~int_we;
         end
      end
   end

   task automatic host_write(input logic [3:0] a, input logic [7:0] d, input int cs);
      int lat;
      lat = -1;
      @(negedge clk);
      fsmc_a = a; d_in = d; ne[cs] = 1'b0;
      @(negedge clk);
      nwe = 1'b0;
      if (cs == CS) begin
         exp_wr.push_back({a, d});
         ref_mem[a] = d;
      end
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (mem_en && mem_we && lat < 0) lat = i;
      end
      nwe = 1'b1;
      @(negedge clk);
      ne[cs] = 1'b1;
      if (cs == CS) check_range("hwr_latency", lat, 3, 5);
      else          check("other_cs_no_write", 32'(lat), 32'hFFFF_FFFF);
      repeat (3) @(negedge clk);
   endtask

   task automatic host_read(input logic [3:0] a);
      @(negedge clk);
      fsmc_a = a; ne[CS] = 1'b0;
      @(negedge clk);
      noe = 1'b0;
      #1 check("d_oe_on", 32'(d_oe), 32'd1);
      repeat (5) @(negedge clk);
      check("hrd_dout", 32'(d_out), 32'(ref_mem[a]));
      last_rd = ref_mem[a];
      @(negedge clk);
      noe = 1'b1;
      #1 check("d_oe_off", 32'(d_oe), 32'd0);
      @(negedge clk);
      ne[CS] = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic engine_op(input logic we, input logic [3:0] a, input logic [7:0] d);
      int w;
      w = 0;
      @(negedge clk);
      int_req = 1'b1; int_we = we; int_addr = a; int_wdata = d;
      if (we) begin
         exp_wr.push_back({a, d});
         ref_mem[a] = d;
      end else begin
         exp_rd.push_back(ref_mem[a]);
      end
      do begin
         @(negedge clk);
         w++;
      end while (!int_gnt && w < 20);
      check("int_gnt_latency", 32'(w), 32'd1);
      int_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic starve_test();
      int   phase, nhost;
      logic prev_en;
      phase = 0; nhost = 0; prev_en = 1'b0; mon_wr_en = 1'b0;
      @(negedge clk);
      fsmc_a = 4'd7; d_in = 8'h5A; ne[CS] = 1'b0;
      int_we = 1'b1; int_addr = 4'd9; int_wdata = 8'h3C;
      for (int c = 0; c < 80 && phase < 3; c++) begin
         @(negedge clk);
         case (phase)
            0: if (prev_en && !mem_en) begin
                  int_req = 1'b1;
                  phase = 1;
               end
            1: if (int_gnt) begin
                  check("starve_host_grants", 32'(nhost), 32'(STARVE_MAX));
                  check("starve_gnt_addr", 32'(mem_addr), 32'd9);
                  check("starve_gnt_data", 32'(mem_wdata), 32'h3C);
                  int_req = 1'b0;
                  phase = 2;
               end else if (mem_en && mem_we) begin
                  nhost++;
               end
            2: if (mem_en) begin
                  check("starve_host_follows", 32'({mem_we, mem_addr}), 32'h17);
                  phase = 3;
               end
            default: ;
         endcase
         prev_en = mem_en;
         nwe = ~nwe;
      end
      check("starve_completed", 32'(phase), 32'd3);
      int_req = 1'b0; nwe = 1'b1; ne[CS] = 1'b1;
      repeat (8) @(negedge clk);
      ref_mem[7] = 8'h5A;
      ref_mem[9] = 8'h3C;
      mon_wr_en = 1'b1;
   endtask

   task automatic bus_err_test(input logic [3:0] a, input logic [7:0] d);
      int nerr, nrd;
      nerr = 0; nrd = 0;
      @(negedge clk);
      fsmc_a = a; d_in = d; ne[CS] = 1'b0;
      @(negedge clk);
      noe = 1'b0; nwe = 1'b0;
      exp_wr.push_back({a, d});
      ref_mem[a] = d;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus_err) nerr++;
         if (mem_en && !mem_we) nrd++;
      end
      noe = 1'b1; nwe = 1'b1;
      @(negedge clk);
      ne[CS] = 1'b1;
      check("bus_err_pulses", 32'(nerr), 32'd1);
      check("bus_err_no_read", 32'(nrd), 32'd0);
      check("bus_err_dout_kept", 32'(d_out), 32'(last_rd));
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dout"}, 32'(d_out), 32'd0);
      check({tag, "_rvalid"}, 32'(int_rvalid), 32'd0);
      check({tag, "_rdata"}, 32'(int_rdata), 32'd0);
      check({tag, "_gnt"}, 32'(int_gnt), 32'd0);
      check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int op;
      rst = 1'b1; bank_load = 1'b1; mon_wr_en = 1'b1; last_rd = 8'h00;
      fsmc_a = '0; ne = 2'b11; noe = 1'b1; nwe = 1'b1; d_in = '0;
      int_req = 1'b0; int_we = 1'b0; int_addr = '0; int_wdata = '0;
      for (int i = 0; i < 16; i++) init_mem[i] = 8'($urandom_range(1, 255));
      init_mem[2] = 8'hA5;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_mem[i];
      repeat (4) @(negedge clk);
      bank_load = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      check("reset_d_oe", 32'(d_oe), 32'd0);

      host_write(4'd4, 8'h16, CS);
      host_read(4'd4);
      engine_op(1'b0, 4'd2, 8'h00);

      // pad enable only follows this block's chip enable
      @(negedge clk);
      ne[1-CS] = 1'b0; noe = 1'b0;
      #1 check("d_oe_other_cs", 32'(d_oe), 32'd0);
      @(negedge clk);
      noe = 1'b1; ne[1-CS] = 1'b1;
      repeat (4) @(negedge clk);

      starve_test();
      host_read(4'd9);
      bus_err_test(4'd11, 8'hC3);
      host_read(4'd11);

      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 4));
         case (op)
            0: host_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), CS);
            1: host_read(4'($urandom_range(0, 15)));
            2: engine_op(1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            3: engine_op(1'b0, 4'($urandom_range(0, 15)), 8'h00);
            default: host_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1 - CS);
         endcase
      end

      // reset while the host read is in HRD_W
      host_write(4'd3, 8'h9C, CS);
      @(negedge clk);
      fsmc_a = 4'd3; ne[CS] = 1'b0;
      @(negedge clk);
      noe = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_hrd_in_read", 32'({mem_en, mem_we}), 32'h2);
      @(negedge clk);
      rst = 1'b1; noe = 1'b1; ne[CS] = 1'b1;
      @(negedge clk);
      check_all_zero("rst_hrd_w");
      rst = 1'b0;
      last_rd = 8'h00;
      repeat (2) @(negedge clk);
      engine_op(1'b0, 4'd3, 8'h00);

      // reset while the engine read is in IRD_W
      @(negedge clk);
      int_req = 1'b1; int_we = 1'b0; int_addr = 4'd3;
      @(negedge clk);
      check("rst_ird_gnt", 32'(int_gnt), 32'd1);
      int_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("rst_ird_w");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ird_no_late_rvalid", 32'(int_rvalid), 32'd0);
      host_read(4'd3);

      repeat (4) @(negedge clk);
      check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
      check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
